// File: rtl/mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OP,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_DATA,
    ST_SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_READ      = 2'b10;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam int         PREAMBLE_LEN = 32;
  localparam int         SKIP_BITS    = 18;
  localparam logic [4:0] REG_ID1      = 5'd2;
  localparam logic [4:0] REG_ID2      = 5'd3;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the system clock domain through matched 2-flop
// synchronizers and flags MDC rising/falling edges.
module mdio_edge_sync (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdc_rise,
  output logic o_mdc_fall,
  output logic o_mdio_bit
);

  logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
  logic mdio_meta_q, mdio_sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdio_meta_q <= 1'b1;
      mdio_sync_q <= 1'b1;
    end else begin
      mdc_meta_q  <= i_mdc;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdio_meta_q <= i_mdio;
      mdio_sync_q <= mdio_meta_q;
    end
  end

  // MDIO has the same two-stage latency as MDC, so the bit seen on a
  // detected fall is the one present at that MDC edge.
  assign o_mdc_rise = mdc_sync_q & ~mdc_prev_q;
  assign o_mdc_fall = ~mdc_sync_q & mdc_prev_q;
  assign o_mdio_bit = mdio_sync_q;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with a 32x16 register file.
// Optional: define MDIO_RESP_PREAMBLE_SUPPRESS_EN to accept frames without preamble after a clean frame.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1620
) (
  input  logic        i_sys_clk,
  input  logic        i_nreset,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic        o_wr_valid,
  output logic [4:0]  o_wr_reg,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err,
  input  logic [4:0]  i_local_reg,
  output logic [15:0] o_local_data
);

  logic mdc_rise, mdc_fall, mdio_bit;

  mdio_edge_sync u_sync (
    .i_clk      (i_sys_clk),
    .i_nreset   (i_nreset),
    .i_mdc      (i_mdc),
    .i_mdio     (i_mdio),
    .o_mdc_rise (mdc_rise),
    .o_mdc_fall (mdc_fall),
    .o_mdio_bit (mdio_bit)
  );

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] shift_q, shift_d;
  logic        mdio_q, mdio_d;
  logic        oe_q, oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];

  logic        supp_ok;
  logic [4:0]  regad_full;
  logic [15:0] wdata_full;
  logic [15:0] snap_val;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  logic last_ok_q, last_ok_d;

  // Cleared when a frame starts, set again only if it returns to IDLE cleanly.
  always_comb begin
    last_ok_d = last_ok_q;
    if (state_q == ST_IDLE && state_d == ST_START)
      last_ok_d = 1'b0;
    else if (state_q != ST_IDLE && state_d == ST_IDLE)
      last_ok_d = !frame_err_d;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_nreset) last_ok_q <= 1'b0;
    else           last_ok_q <= last_ok_d;
  end

  assign supp_ok = last_ok_q;
`else
  assign supp_ok = 1'b0;
`endif

  assign regad_full = {reg_q[3:0], mdio_bit};
  assign wdata_full = {shift_q[14:0], mdio_bit};

  always_comb begin
    if (regad_full == REG_ID1)      snap_val = PHY_ID1;
    else if (regad_full == REG_ID2) snap_val = PHY_ID2;
    else                            snap_val = regs_q[regad_full];
  end

  always_comb begin
    if (i_local_reg == REG_ID1)      o_local_data = PHY_ID1;
    else if (i_local_reg == REG_ID2) o_local_data = PHY_ID2;
    else                             o_local_data = regs_q[i_local_reg];
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    shift_d     = shift_q;
    mdio_d      = mdio_q;
    oe_d        = oe_q;
    wr_valid_d  = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: if (mdc_fall) begin
        if (mdio_bit) begin
          if (pre_cnt_q != 6'(PREAMBLE_LEN)) pre_cnt_d = pre_cnt_q + 6'd1;
        end else if (pre_cnt_q == 6'(PREAMBLE_LEN) || supp_ok) begin
          state_d   = ST_START;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = '0;
        end
      end

      ST_START: if (mdc_fall) begin
        cnt_d = '0;
        if (mdio_bit) begin
          state_d = ST_OP;
        end else begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end
      end

      ST_OP: if (mdc_fall) begin
        op_d = {op_q[0], mdio_bit};
        if (cnt_q == 5'd1) begin
          cnt_d = '0;
          if ({op_q[0], mdio_bit} == OP_READ || {op_q[0], mdio_bit} == OP_WRITE) begin
            state_d = ST_PHYAD;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_PHYAD: if (mdc_fall) begin
        phy_d = {phy_q[3:0], mdio_bit};
        if (cnt_q == 5'd4) begin
          cnt_d   = '0;
          state_d = ST_REGAD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_REGAD: if (mdc_fall) begin
        reg_d = regad_full;
        if (cnt_q == 5'd4) begin
          cnt_d = '0;
          if (phy_q != PHY_ADDR) begin
            state_d = ST_SKIP;
          end else begin
            state_d = ST_TA;
            if (op_q == OP_READ) shift_d = snap_val;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_SKIP: if (mdc_fall) begin
        if (cnt_q == 5'(SKIP_BITS - 1)) state_d = ST_IDLE;
        else                            cnt_d = cnt_q + 5'd1;
      end

      // Read turnaround/data advance on MDC rise; write on MDC fall.
      ST_TA: begin
        if (op_q == OP_READ) begin
          if (mdc_rise) begin
            if (cnt_q == 5'd0) begin
              cnt_d  = 5'd1;
              mdio_d = 1'b1;
              oe_d   = 1'b0;
            end else begin
              cnt_d   = '0;
              mdio_d  = 1'b0;
              oe_d    = 1'b1;
              state_d = ST_DATA;
            end
          end
        end else if (mdc_fall) begin
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (op_q == OP_READ) begin
          if (mdc_rise) begin
            if (!cnt_q[4]) begin
              mdio_d  = shift_q[15];
              oe_d    = 1'b1;
              shift_d = {shift_q[14:0], 1'b0};
              cnt_d   = cnt_q + 5'd1;
            end else begin
              mdio_d  = 1'b1;
              oe_d    = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end else if (mdc_fall) begin
          shift_d = wdata_full;
          if (cnt_q == 5'd15) begin
            state_d = ST_IDLE;
            if (reg_q != REG_ID1 && reg_q != REG_ID2) begin
              regs_d[reg_q] = wdata_full;
              wr_valid_d    = 1'b1;
              wr_reg_d      = reg_q;
              wr_data_d     = wdata_full;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_nreset) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      phy_q       <= '0;
      reg_q       <= '0;
      shift_q     <= '0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      shift_q     <= shift_d;
      mdio_q      <= mdio_d;
      oe_q        <= oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  assign o_mdio      = mdio_q;
  assign o_mdio_oe   = oe_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_reg    = wr_reg_q;
  assign o_wr_data   = wr_data_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: clause-22 PHY address this responder answers.
REQ-002 SHALL have parameter PHY_ID1, default 16'h0022: read-only value of register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h1620: read-only value of register 3.
REQ-004 SHALL have port i_sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_nreset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_mdc  in  1  management clock from station, asynchronous.
REQ-007 SHALL have port i_mdio  in  1  MDIO pad input, asynchronous.
REQ-008 SHALL have port o_mdio  out  1  MDIO drive value; the top level builds the tristate.
REQ-009 SHALL have port o_mdio_oe  out  1  MDIO drive enable.
REQ-010 SHALL have port o_wr_valid  out  1  one-cycle pulse on each accepted register write.
REQ-011 SHALL have port o_wr_reg  out  5  register address of the accepted write.
REQ-012 SHALL have port o_wr_data  out  16  data of the accepted write.
REQ-013 SHALL have port o_frame_err  out  1  one-cycle pulse on a malformed frame.
REQ-014 SHALL have port i_local_reg  in  5  local read-port address.
REQ-015 SHALL have port o_local_data  out  16  register-file contents at i_local_reg, combinational.

Function
REQ-016 SHALL pass i_mdc and i_mdio through matched 2-flop synchronizers, then detect synchronized MDC rising and falling edges.
REQ-017 SHALL sample MDIO bits on detected MDC falling edges and SHALL update o_mdio on detected MDC rising edges, because the station changes data with MDC rising.
REQ-018 SHALL implement states IDLE, START, OP, PHYAD, REGAD, TA, DATA and SKIP.
REQ-019 IDLE SHALL count consecutive sampled 1s, saturating at 32; a sampled 0 with count=32 SHALL enter START, and a sampled 0 with count<32 SHALL clear the count.
REQ-020 START SHALL require a sampled 1, which completes ST=01; otherwise o_frame_err SHALL pulse and the state SHALL return to IDLE.
REQ-021 OP SHALL capture 2 bits; 10=read and 01=write; 00 or 11 SHALL pulse o_frame_err and return to IDLE.
REQ-022 PHYAD and REGAD SHALL each capture 5 bits MSB-first.
REQ-023 At the end of REGAD, a PHYAD mismatch SHALL enter SKIP, which counts 18 bits and then returns to IDLE with o_mdio_oe held 0.
REQ-024 Read with PHYAD match: the 16-bit register value SHALL be snapshotted at the end of REGAD.
REQ-025 Read TA: o_mdio_oe SHALL stay 0 for the first TA bit, and o_mdio=0 with o_mdio_oe=1 SHALL be driven for the second.
REQ-026 Read DATA: the snapshot SHALL be driven MSB-first for 16 bit-times; o_mdio_oe SHALL deassert on the MDC rising edge after bit 0, and the state SHALL return to IDLE.
REQ-027 Write TA: 2 bits SHALL be consumed without checking.
REQ-028 Write DATA: 16 bits SHALL be shifted in MSB-first; after the 16th falling-edge sample the register SHALL be updated and o_wr_valid SHALL pulse with o_wr_reg and o_wr_data, and the state SHALL return to IDLE.
REQ-029 The register file SHALL hold 32 x 16 bits; registers 2 and 3 SHALL return PHY_ID1 and PHY_ID2, and writes to them SHALL be ignored with no o_wr_valid pulse.
REQ-030 An MDC edge coinciding with a local read SHALL have no effect on o_local_data beyond the same-cycle register update.

Reset
REQ-031 i_nreset=0 at a clock edge SHALL force IDLE, clear the preamble count, and clear every writable register to 16'h0000.
REQ-032 i_nreset=0 SHALL force o_mdio=1, o_mdio_oe=0, o_wr_valid=0, o_wr_reg=0, o_wr_data=0 and o_frame_err=0.
REQ-033 Reset during an active read SHALL release MDIO on the next clock edge.

Configuration
REQ-034 Macro MDIO_RESP_PREAMBLE_SUPPRESS_EN, when defined, SHALL allow a sampled 0 in IDLE to enter START with any preamble count, provided the previous frame completed without error.
REQ-035 Without MDIO_RESP_PREAMBLE_SUPPRESS_EN, 32 preamble 1s SHALL always be required.

Structure
REQ-036 Package mdio_pkg SHALL hold the state enum, the OP_READ/OP_WRITE constants, PREAMBLE_LEN=32 and the ID register indices.
REQ-037 Sub-module mdio_edge_sync SHALL provide the synchronizer and edge detector, instantiated once for MDC and MDIO together.

Verification
REQ-038 The bench SHALL write reg 5 = 16'hA5C3 at PHY 1, then read reg 5: expect o_wr_valid once with reg=5 and data=A5C3, and read data A5C3 with TA driven as Z,0.
REQ-039 The bench SHALL read reg 2: expect 16'h0022; it SHALL then write reg 2 = FFFF, re-read, and expect 0022 with no o_wr_valid.
REQ-040 The bench SHALL write at PHY 7: expect no o_wr_valid, o_mdio_oe=0 throughout, and the next frame at PHY 1 accepted.
REQ-041 The bench SHALL send 31-bit preamble + write: without the macro expect no write; with the macro, after a prior good frame, expect the write accepted.
REQ-042 The bench SHALL send OP=11: expect one o_frame_err pulse and IDLE; a following valid read SHALL succeed.
REQ-043 The bench SHALL assert i_nreset=0 at read data bit 8: expect o_mdio_oe=0 next cycle and all registers reading 0000 except regs 2 and 3.
